// File: rtl/acsp_pkg.sv
// acsp_pkg: shared types and constants for the capture readout path.
package acsp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_FLAGS,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_PAYLOAD,
        ST_CHKSUM,
        ST_DONE
    } readout_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FLAG_RLE_BIT      = 0;

    // FLAGS header byte; only the RLE bit is ever set.
    function automatic logic [7:0] flags_byte(input logic rle_on);
        return rle_on ? (8'h01 << FLAG_RLE_BIT) : 8'h00;
    endfunction

endpackage

// File: rtl/capture_readout_rle.sv
// rle_encoder: folds a sample stream into (value, run-1) pairs, runs capped at 256.
// Exists only when CAPTURE_READOUT_RLE_EN is defined.
`ifdef CAPTURE_READOUT_RLE_EN
module rle_encoder (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       pair_valid,
    output logic [7:0] pair_value,
    output logic [7:0] pair_run,
    input  logic       pair_ready,
    output logic       idle
);
    logic       active;
    logic       flush;
    logic [7:0] cur_value;
    logic [7:0] run_cnt;

    // A new sample is only taken when a run break could be emitted immediately.
    assign in_ready = !pair_valid && !flush;
    assign idle     = !active && !flush && !pair_valid;

    // Run tracking and pair emission; the last sample forces the open run out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active     <= 1'b0;
            flush      <= 1'b0;
            cur_value  <= '0;
            run_cnt    <= '0;
            pair_valid <= 1'b0;
            pair_value <= '0;
            pair_run   <= '0;
        end else begin
            if (pair_valid && pair_ready)
                pair_valid <= 1'b0;
            if (in_valid && in_ready) begin
                if (active && (in_data != cur_value || run_cnt == 8'hFF)) begin
                    pair_valid <= 1'b1;
                    pair_value <= cur_value;
                    pair_run   <= run_cnt;
                    cur_value  <= in_data;
                    run_cnt    <= '0;
                end else if (active) begin
                    run_cnt <= run_cnt + 8'd1;
                end else begin
                    cur_value <= in_data;
                    run_cnt   <= '0;
                    active    <= 1'b1;
                end
                flush <= in_last;
            end else if (flush && !pair_valid) begin
                pair_valid <= 1'b1;
                pair_value <= cur_value;
                pair_run   <= run_cnt;
                active     <= 1'b0;
                flush      <= 1'b0;
            end
        end
    end
endmodule
`endif

// File: rtl/capture_readout.sv
// capture_readout: drains the sample FIFO and frames it as
// SYNC, FLAGS, COUNT_HI, COUNT_LO, payload, CHECKSUM toward the host link.
// Build option CAPTURE_READOUT_RLE_EN: payload is run-length encoded.
//
// state      | meaning
// ST_IDLE    | waiting for start
// ST_SYNC    | presenting sync byte
// ST_FLAGS   | presenting flags byte
// ST_CNT_HI  | presenting count[15:8]
// ST_CNT_LO  | presenting count[7:0]
// ST_PAYLOAD | popping FIFO and sending payload bytes
// ST_CHKSUM  | presenting XOR of payload bytes
// ST_DONE    | one-cycle done pulse
module capture_readout
    import acsp_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
    parameter int         COUNT_WIDTH = 16
) (
    input  logic                   system_clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] sample_count,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [7:0]             fifo_dout,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   done
);
`ifdef CAPTURE_READOUT_RLE_EN
    localparam logic [7:0] FLAGS_VALUE = flags_byte(1'b1);
`else
    localparam logic [7:0] FLAGS_VALUE = flags_byte(1'b0);
`endif

    readout_state_t         state;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] reads_remaining;
    logic                   read_pending;
    logic [7:0]             checksum;
    logic                   tx_fire;
    logic                   payload_last;

    assign tx_fire = tx_valid && tx_ready;

`ifdef CAPTURE_READOUT_RLE_EN
    logic       samp_valid;
    logic       samp_last;
    logic [7:0] samp_data;
    logic       enc_in_ready;
    logic       pair_valid;
    logic       pair_ready;
    logic [7:0] pair_value;
    logic [7:0] pair_run;
    logic       enc_idle;
    logic       run_phase;
    logic [7:0] run_hold;

    assign pair_ready   = (state == ST_PAYLOAD) && !tx_valid;
    assign fifo_rd_en   = (state == ST_PAYLOAD) && (reads_remaining != '0) && !fifo_empty &&
                          !read_pending && (!samp_valid || enc_in_ready);
    assign payload_last = run_phase && (reads_remaining == '0) && !read_pending &&
                          !samp_valid && enc_idle;

    rle_encoder u_rle (
        .clk        (system_clock),
        .reset_n    (reset_n),
        .in_valid   (samp_valid),
        .in_data    (samp_data),
        .in_last    (samp_last),
        .in_ready   (enc_in_ready),
        .pair_valid (pair_valid),
        .pair_value (pair_value),
        .pair_run   (pair_run),
        .pair_ready (pair_ready),
        .idle       (enc_idle)
    );

    // Holding register between the FIFO read port and the encoder.
    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            samp_valid <= 1'b0;
            samp_last  <= 1'b0;
            samp_data  <= '0;
        end else begin
            if (samp_valid && enc_in_ready)
                samp_valid <= 1'b0;
            if (read_pending) begin
                samp_valid <= 1'b1;
                samp_data  <= fifo_dout;
                samp_last  <= (reads_remaining == '0);
            end
        end
    end
`else
    // tx_data/tx_valid act as the holding register; a pop may overlap its drain.
    assign fifo_rd_en   = (state == ST_PAYLOAD) && (reads_remaining != '0) && !fifo_empty &&
                          !read_pending && (!tx_valid || tx_ready);
    assign payload_last = (reads_remaining == '0) && !read_pending;
`endif

    // Packet sequencer with registered link outputs, read bookkeeping and checksum.
    always_ff @(posedge system_clock) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            count_q         <= '0;
            reads_remaining <= '0;
            read_pending    <= 1'b0;
            checksum        <= '0;
            tx_data         <= '0;
            tx_valid        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
`ifdef CAPTURE_READOUT_RLE_EN
            run_phase       <= 1'b0;
            run_hold        <= '0;
`endif
        end else begin
            done         <= 1'b0;
            read_pending <= fifo_rd_en;
            if (fifo_rd_en)
                reads_remaining <= reads_remaining - COUNT_WIDTH'(1);
            unique case (state)
                ST_IDLE: if (start) begin
                    count_q         <= sample_count;
                    reads_remaining <= sample_count;
                    checksum        <= '0;
                    busy            <= 1'b1;
                    tx_valid        <= 1'b1;
                    tx_data         <= SYNC_BYTE;
                    state           <= ST_SYNC;
                end
                ST_SYNC: if (tx_fire) begin
                    tx_data <= FLAGS_VALUE;
                    state   <= ST_FLAGS;
                end
                ST_FLAGS: if (tx_fire) begin
                    tx_data <= count_q[15:8];
                    state   <= ST_CNT_HI;
                end
                ST_CNT_HI: if (tx_fire) begin
                    tx_data <= count_q[7:0];
                    state   <= ST_CNT_LO;
                end
                ST_CNT_LO: if (tx_fire) begin
                    if (count_q == '0) begin
                        tx_data <= 8'h00;
                        state   <= ST_CHKSUM;
                    end else begin
                        tx_valid <= 1'b0;
                        state    <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
`ifdef CAPTURE_READOUT_RLE_EN
                    if (pair_valid && pair_ready) begin
                        tx_data   <= pair_value;
                        run_hold  <= pair_run;
                        run_phase <= 1'b0;
                        tx_valid  <= 1'b1;
                    end else if (tx_fire) begin
                        checksum <= checksum ^ tx_data;
                        if (!run_phase) begin
                            tx_data   <= run_hold;
                            run_phase <= 1'b1;
                        end else if (payload_last) begin
                            tx_data <= checksum ^ tx_data;
                            state   <= ST_CHKSUM;
                        end else begin
                            tx_valid <= 1'b0;
                        end
                    end
`else
                    if (read_pending) begin
                        tx_data  <= fifo_dout;
                        tx_valid <= 1'b1;
                    end else if (tx_fire) begin
                        checksum <= checksum ^ tx_data;
                        if (payload_last) begin
                            tx_data <= checksum ^ tx_data;
                            state   <= ST_CHKSUM;
                        end else begin
                            tx_valid <= 1'b0;
                        end
                    end
`endif
                end
                ST_CHKSUM: if (tx_fire) begin
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_capture_readout.sv
// tb_capture_readout: directed and randomized packets against a packet-level model.
module tb_capture_readout;
    logic        system_clock = 1'b0;
    logic        reset_n      = 1'b0;
    logic        start        = 1'b0;
    logic [15:0] sample_count = '0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout    = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready     = 1'b1;
    logic        busy;
    logic        done;

`ifdef CAPTURE_READOUT_RLE_EN
    localparam bit RLE = 1'b1;
`else
    localparam bit RLE = 1'b0;
`endif

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] mem [0:4095];
    int         rd_ptr      = 0;
    int         wr_ptr      = 0;
    logic       force_empty = 1'b0;
    logic [7:0] rx [$];
    logic [7:0] exp_q [$];
    int         pops  = 0;
    int         dones = 0;
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [7:0] prev_d = '0;

    always #5 system_clock = ~system_clock;

    assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

    capture_readout dut (
        .system_clock (system_clock),
        .reset_n      (reset_n),
        .start        (start),
        .sample_count (sample_count),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_dout    (fifo_dout),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done)
    );

    // Sample FIFO with one-cycle read latency.
    always @(posedge system_clock) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr % 4096];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Link monitor: collects handshaked bytes, pops, done pulses; checks stall stability.
    always @(negedge system_clock) begin
        if (!reset_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("stall_valid", tx_valid, 1);
                chk("stall_data", tx_data, prev_d);
            end
            if (fifo_empty)
                chk("pop_while_empty", fifo_rd_en, 0);
            if (tx_valid && tx_ready) rx.push_back(tx_data);
            if (fifo_rd_en) pops++;
            if (done) begin
                dones++;
                chk("done_busy", busy, 0);
            end
            prev_v = tx_valid;
            prev_r = tx_ready;
            prev_d = tx_data;
        end
    end

    task automatic load(input logic [7:0] v);
        mem[wr_ptr % 4096] = v;
        wr_ptr++;
    endtask

    // Expected packet straight from the framing rules.
    task automatic build_expected(input int base, input int count);
        logic [7:0] pay [$];
        logic [7:0] c;
        logic [7:0] v;
        int         i;
        int         n;
        c = '0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(RLE ? 8'h01 : 8'h00);
        exp_q.push_back(count[15:8]);
        exp_q.push_back(count[7:0]);
        i = 0;
        while (i < count) begin
            v = mem[(base + i) % 4096];
            if (!RLE) begin
                pay.push_back(v);
                i++;
            end else begin
                n = 1;
                while (i + n < count && n < 256 && mem[(base + i + n) % 4096] == v) n++;
                pay.push_back(v);
                pay.push_back(8'(n - 1));
                i += n;
            end
        end
        foreach (pay[k]) begin
            exp_q.push_back(pay[k]);
            c ^= pay[k];
        end
        exp_q.push_back(c);
    endtask

    // mode 0: ready high, 1: 1,0,1,0 with a 5-cycle stall, 2: random + spurious start, 3: forced empty
    task automatic run_packet(input int count, input int mode, input string tag);
        int cyc;
        int hold_cnt;
        bit forced;
        build_expected(rd_ptr, count);
        rx.delete();
        pops  = 0;
        dones = 0;
        @(posedge system_clock); #1;
        sample_count = count[15:0];
        start    = 1'b1;
        tx_ready = 1'b1;
        @(negedge system_clock);
        chk({tag, "_pre_busy"}, busy, 0);
        chk({tag, "_pre_valid"}, tx_valid, 0);
        @(posedge system_clock); #1;
        start = 1'b0;
        @(negedge system_clock);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_sync_valid"}, tx_valid, 1);
        chk({tag, "_sync_data"}, tx_data, 8'hA5);
        cyc = 0; hold_cnt = 0; forced = 0;
        while (dones == 0 && cyc < 3000) begin
            @(posedge system_clock); #1;
            cyc++;
            case (mode)
                1:       tx_ready = (cyc >= 12 && cyc < 17) ? 1'b0 : ((cyc % 2) == 1);
                2:       tx_ready = ($urandom_range(0, 3) != 0);
                default: tx_ready = 1'b1;
            endcase
            start        = (mode == 2 && cyc == 7);
            sample_count = start ? 16'(count + 5) : count[15:0];
            if (mode == 3) begin
                if (!forced && pops == 2) begin
                    force_empty = 1'b1;
                    forced      = 1;
                    hold_cnt    = 10;
                end else if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) begin
                        chk({tag, "_drained_valid"}, tx_valid, 0);
                        force_empty = 1'b0;
                    end
                end
            end
        end
        chk({tag, "_done_seen"}, (dones > 0), 1);
        @(posedge system_clock); #1;
        start    = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge system_clock);
        #1;
        chk({tag, "_done_once"}, dones, 1);
        chk({tag, "_busy_after"}, busy, 0);
        chk({tag, "_valid_after"}, tx_valid, 0);
        chk({tag, "_pops"}, pops, count);
        chk({tag, "_len"}, rx.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (k < rx.size())
                chk($sformatf("%s_byte%0d", tag, k), rx[k], exp_q[k]);
    endtask

    initial begin
        int cyc;
        int n;
        logic [7:0] v;

        repeat (3) @(posedge system_clock);
        @(negedge system_clock);
        chk("rst_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_data", tx_data, 0);
        @(posedge system_clock); #1;
        reset_n = 1'b1;

        // basic packet
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        run_packet(4, 0, "t1");
        if (!RLE) chk("t1_cks_const", rx[8], 8'h44);

        // empty packet
        run_packet(0, 0, "t2");

        // backpressure
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        run_packet(4, 1, "t3");

        // FIFO runs dry mid-payload
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        run_packet(4, 3, "t4");

        // reset during payload, then a clean packet
        for (int i = 0; i < 8; i++) load(8'(8'h60 + i));
        pops = 0;
        @(posedge system_clock); #1;
        sample_count = 16'd8;
        start        = 1'b1;
        @(posedge system_clock); #1;
        start = 1'b0;
        cyc = 0;
        while (pops < 3 && cyc < 200) begin
            @(posedge system_clock); #1;
            cyc++;
        end
        chk("t5_reached_payload", (pops >= 3), 1);
        reset_n = 1'b0;
        @(posedge system_clock); #1;
        reset_n = 1'b1;
        @(negedge system_clock);
        chk("t5_rst_valid", tx_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rd_en", fifo_rd_en, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_data", tx_data, 0);
        wr_ptr = rd_ptr;
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        run_packet(4, 0, "t5");

`ifdef CAPTURE_READOUT_RLE_EN
        load(8'h07); load(8'h07); load(8'h07); load(8'h09); load(8'h09); load(8'h07);
        run_packet(6, 0, "t6");
        chk("t6_cks_const", rx[10], 8'h0A);
        for (int i = 0; i < 300; i++) load(8'h55);
        run_packet(300, 0, "t6b");
        chk("t6b_run0", rx[5], 8'hFF);
        chk("t6b_run1", rx[7], 8'h2B);
`endif

        // randomized packets
        for (int p = 0; p < 3; p++) begin
            n = $urandom_range(20, 60);
            v = 8'($urandom_range(0, 255));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) v = 8'($urandom_range(0, 255));
                load(v);
            end
            run_packet(n, 2, $sformatf("rnd%0d", p));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
